// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: opcodes, micro-step codes and control-word bit indices.
// The ALU and bus muxes decode the control word with the same indices.
package sap1_pkg;

    localparam int OPCODE_WIDTH = 4;
    localparam int STEP_WIDTH   = 3;
    localparam int CTRL_WIDTH   = 16;

    localparam logic [OPCODE_WIDTH-1:0] OP_NOP = 4'h0;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDA = 4'h1;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 4'h2;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB = 4'h3;
    localparam logic [OPCODE_WIDTH-1:0] OP_STA = 4'h4;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDI = 4'h5;
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP = 4'h6;
    localparam logic [OPCODE_WIDTH-1:0] OP_JC  = 4'h7;
    localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = 4'h8;
    localparam logic [OPCODE_WIDTH-1:0] OP_JO  = 4'h9;
    localparam logic [OPCODE_WIDTH-1:0] OP_OUT = 4'hE;
    localparam logic [OPCODE_WIDTH-1:0] OP_HLT = 4'hF;

    localparam logic [STEP_WIDTH-1:0] T0 = 3'd0;
    localparam logic [STEP_WIDTH-1:0] T1 = 3'd1;
    localparam logic [STEP_WIDTH-1:0] T2 = 3'd2;
    localparam logic [STEP_WIDTH-1:0] T3 = 3'd3;
    localparam logic [STEP_WIDTH-1:0] T4 = 3'd4;

    localparam int CTRL_PC_INC          = 0;
    localparam int CTRL_PC_OUT          = 1;
    localparam int CTRL_PC_LOAD         = 2;
    localparam int CTRL_MAR_LOAD        = 3;
    localparam int CTRL_RAM_OUT         = 4;
    localparam int CTRL_RAM_IN          = 5;
    localparam int CTRL_IR_LOAD         = 6;
    localparam int CTRL_IR_OUT          = 7;
    localparam int CTRL_A_LOAD          = 8;
    localparam int CTRL_A_OUT           = 9;
    localparam int CTRL_B_LOAD          = 10;
    localparam int CTRL_ALU_OUT         = 11;
    localparam int CTRL_ALU_SUB         = 12;
    localparam int CTRL_ALU_LATCH_FLAGS = 13;
    localparam int CTRL_OUT_LOAD        = 14;
    localparam int CTRL_HALT            = 15;

    // One-hot control word with only the given bit set.
    function automatic logic [CTRL_WIDTH-1:0] cbit(input int idx);
        logic [CTRL_WIDTH-1:0] w;
        w      = '0;
        w[idx] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/sap1_microcode.sv
// Combinational microcode ROM: (opcode, step, flags) -> control word and last-step marker.
module sap1_microcode
    import sap1_pkg::*;
(
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [STEP_WIDTH-1:0]   step,
    input  logic                    zero,
    input  logic                    carry,
    input  logic                    odd,
    output logic [CTRL_WIDTH-1:0]   ctrl,
    output logic                    last
);

    // Decode one micro-step; undefined opcodes and steps fall through as a terminating NOP.
    always_comb begin
        ctrl = '0;
        last = 1'b0;
        case (step)
            T0: ctrl = cbit(CTRL_PC_OUT) | cbit(CTRL_MAR_LOAD);
            T1: ctrl = cbit(CTRL_RAM_OUT) | cbit(CTRL_IR_LOAD) | cbit(CTRL_PC_INC);
            T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl = cbit(CTRL_IR_OUT) | cbit(CTRL_MAR_LOAD);
                    end
                    OP_LDI: begin
                        ctrl = cbit(CTRL_IR_OUT) | cbit(CTRL_A_LOAD);
                        last = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl = cbit(CTRL_IR_OUT) | cbit(CTRL_PC_LOAD);
                        last = 1'b1;
                    end
                    OP_JC: begin
                        ctrl = cbit(CTRL_IR_OUT) | (carry ? cbit(CTRL_PC_LOAD) : 16'h0000);
                        last = 1'b1;
                    end
                    OP_JZ: begin
                        ctrl = cbit(CTRL_IR_OUT) | (zero ? cbit(CTRL_PC_LOAD) : 16'h0000);
                        last = 1'b1;
                    end
                    OP_JO: begin
                        ctrl = cbit(CTRL_IR_OUT) | (odd ? cbit(CTRL_PC_LOAD) : 16'h0000);
                        last = 1'b1;
                    end
                    OP_OUT: begin
                        ctrl = cbit(CTRL_A_OUT) | cbit(CTRL_OUT_LOAD);
                        last = 1'b1;
                    end
                    OP_HLT: begin
                        ctrl = cbit(CTRL_HALT);
                        last = 1'b1;
                    end
                    default: last = 1'b1;
                endcase
            end
            T3: begin
                case (opcode)
                    OP_LDA: begin
                        ctrl = cbit(CTRL_RAM_OUT) | cbit(CTRL_A_LOAD);
                        last = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl = cbit(CTRL_RAM_OUT) | cbit(CTRL_B_LOAD);
                    end
                    OP_STA: begin
                        ctrl = cbit(CTRL_A_OUT) | cbit(CTRL_RAM_IN);
                        last = 1'b1;
                    end
                    default: last = 1'b1;
                endcase
            end
            T4: begin
                case (opcode)
                    OP_ADD: begin
                        ctrl = cbit(CTRL_ALU_OUT) | cbit(CTRL_A_LOAD) | cbit(CTRL_ALU_LATCH_FLAGS);
                        last = 1'b1;
                    end
                    OP_SUB: begin
                        ctrl = cbit(CTRL_ALU_OUT) | cbit(CTRL_A_LOAD) | cbit(CTRL_ALU_LATCH_FLAGS)
                             | cbit(CTRL_ALU_SUB);
                        last = 1'b1;
                    end
                    default: last = 1'b1;
                endcase
            end
            default: last = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// SAP-1 micro-step sequencer: step/halt registers, reset gating and the halt transition.
// The control word itself comes from sap1_microcode.
module control_sequencer #(
    parameter int OPCODE_WIDTH = 4,
    parameter int STEP_WIDTH   = 3,
    parameter int CTRL_WIDTH   = 16
) (
    input  logic                    clk,
    input  logic                    i_rst,
    input  logic                    clk_en,
    input  logic [OPCODE_WIDTH-1:0] i_opcode,
    input  logic                    i_zero,
    input  logic                    i_carry,
    input  logic                    i_odd,
    output logic [CTRL_WIDTH-1:0]   o_ctrl,
    output logic [STEP_WIDTH-1:0]   o_step,
    output logic                    o_halted
);

    import sap1_pkg::*;

    logic [STEP_WIDTH-1:0] step_r;
    logic                  halted_r;
    logic [CTRL_WIDTH-1:0] ucode_ctrl_s;
    logic                  last_s;

    sap1_microcode u_microcode (
        .opcode (i_opcode),
        .step   (step_r),
        .zero   (i_zero),
        .carry  (i_carry),
        .odd    (i_odd),
        .ctrl   (ucode_ctrl_s),
        .last   (last_s)
    );

    // Step/halt state: reset wins, halted state ignores clk_en, HLT parks the step at T0.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            step_r   <= T0;
            halted_r <= 1'b0;
        end else if (halted_r) begin
            step_r   <= T0;
            halted_r <= 1'b1;
        end else if (clk_en) begin
            if (ucode_ctrl_s[CTRL_HALT]) begin
                step_r   <= T0;
                halted_r <= 1'b1;
            end else if (last_s) begin
                step_r   <= T0;
            end else begin
                step_r   <= step_r + 3'd1;
            end
        end else begin
            step_r   <= step_r;
            halted_r <= halted_r;
        end
    end

    // Control word gating: silent during reset, halt bit only while halted.
    always_comb begin
        o_ctrl = '0;
        if (i_rst) begin
            o_ctrl = '0;
        end else if (halted_r) begin
            o_ctrl = cbit(CTRL_HALT);
        end else begin
            o_ctrl = ucode_ctrl_s;
        end
    end

    assign o_step   = step_r;
    assign o_halted = halted_r;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed program fragments, a full opcode/flag
// sweep and random traffic, all checked against a list-of-micro-steps reference model.
module tb_control_sequencer;

    localparam logic [15:0] PI  = 16'h0001, PO  = 16'h0002, PL = 16'h0004, ML = 16'h0008;
    localparam logic [15:0] RO  = 16'h0010, RI  = 16'h0020, IL = 16'h0040, IO = 16'h0080;
    localparam logic [15:0] AL  = 16'h0100, AO  = 16'h0200, BL = 16'h0400, EO = 16'h0800;
    localparam logic [15:0] SU  = 16'h1000, FL  = 16'h2000, OL = 16'h4000, HT = 16'h8000;

    logic        clk = 1'b0;
    logic        i_rst, clk_en, i_zero, i_carry, i_odd;
    logic [3:0]  i_opcode;
    logic [15:0] o_ctrl;
    logic [2:0]  o_step;
    logic        o_halted;

    typedef logic [15:0] words_t[$];
    typedef struct {
        logic [15:0] ctrl;
        int          step;
        bit          halted;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   n_id  = 0;
    int   m_pos = 0;
    bit   m_halt = 1'b0;

    control_sequencer dut (
        .clk      (clk),
        .i_rst    (i_rst),
        .clk_en   (clk_en),
        .i_opcode (i_opcode),
        .i_zero   (i_zero),
        .i_carry  (i_carry),
        .i_odd    (i_odd),
        .o_ctrl   (o_ctrl),
        .o_step   (o_step),
        .o_halted (o_halted)
    );

    always #5 clk = ~clk;

    // Whole instruction as the list of control words it produces, fetch included.
    function automatic words_t micro(input logic [3:0] op, input logic z, input logic c, input logic o);
        words_t w;
        w.push_back(PO | ML);
        w.push_back(RO | IL | PI);
        case (op)
            4'h1: begin w.push_back(IO | ML); w.push_back(RO | AL); end
            4'h2: begin w.push_back(IO | ML); w.push_back(RO | BL); w.push_back(EO | AL | FL); end
            4'h3: begin w.push_back(IO | ML); w.push_back(RO | BL); w.push_back(EO | AL | FL | SU); end
            4'h4: begin w.push_back(IO | ML); w.push_back(AO | RI); end
            4'h5: w.push_back(IO | AL);
            4'h6: w.push_back(IO | PL);
            4'h7: w.push_back(c ? (IO | PL) : IO);
            4'h8: w.push_back(z ? (IO | PL) : IO);
            4'h9: w.push_back(o ? (IO | PL) : IO);
            4'hE: w.push_back(AO | OL);
            4'hF: w.push_back(HT);
            default: w.push_back(16'h0000);
        endcase
        return w;
    endfunction

    // One clock of stimulus; queues either a given expectation or the model's, then advances the model.
    task automatic drive(input bit rst, input bit en, input logic [3:0] op, input logic [2:0] fl,
                         input bit directed, input logic [15:0] ec, input int es, input bit eh);
        exp_t   e;
        words_t w;
        logic [15:0] cur;
        i_rst    = rst;
        clk_en   = en;
        i_opcode = op;
        {i_zero, i_carry, i_odd} = fl;
        w   = micro(op, fl[2], fl[1], fl[0]);
        cur = (m_pos < w.size()) ? w[m_pos] : 16'h0000;
        if (directed) e = '{ec, es, eh, n_id};
        else          e = '{rst ? 16'h0000 : (m_halt ? HT : cur), m_pos, m_halt, n_id};
        sb.push_back(e);
        n_id++;
        if (rst) begin
            m_pos  = 0;
            m_halt = 1'b0;
        end else if (!m_halt && en) begin
            if (cur == HT) begin
                m_halt = 1'b1;
                m_pos  = 0;
            end else if (m_pos >= w.size() - 1) begin
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [3:0] op);
        drive(1'b0, 1'b1, op, 3'b000, 1'b1, 16'h000A, 0, 1'b0);
        drive(1'b0, 1'b1, op, 3'b000, 1'b1, 16'h0051, 1, 1'b0);
    endtask

    // Monitor: pop one expectation per cycle, compare, and check bus exclusivity and step range.
    always @(negedge clk) begin : monitor
        exp_t e;
        int   n;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            if (o_ctrl !== e.ctrl || o_step !== 3'(e.step) || o_halted !== e.halted) begin
                bad++;
                $display("FAIL chk%0d got ctrl=%h step=%0d halted=%0b want ctrl=%h step=%0d halted=%0b",
                         e.id, o_ctrl, o_step, o_halted, e.ctrl, e.step, e.halted);
            end
            n = int'(o_ctrl[1]) + int'(o_ctrl[4]) + int'(o_ctrl[7]) + int'(o_ctrl[9]) + int'(o_ctrl[11]);
            total++;
            if (n > 1 || o_step > 3'd4) begin
                bad++;
                $display("FAIL bus_excl chk%0d got outs=%0d step=%0d want outs<=1 step<=4", e.id, n, o_step);
            end
        end
    end

    initial begin
        logic [2:0] masks [3];
        logic [3:0] jops  [3];
        logic [3:0] cur_op;
        masks = '{3'b010, 3'b100, 3'b001};
        jops  = '{4'h7, 4'h8, 4'h9};
        cur_op = 4'h0;
        i_rst = 1'b1; clk_en = 1'b0; i_opcode = 4'h0; {i_zero, i_carry, i_odd} = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 4'h0, 3'b000, 1'b1, 16'h0000, 0, 1'b0);

        fetch(4'h2);
        drive(1'b0, 1'b1, 4'h2, 3'b000, 1'b1, 16'h0088, 2, 1'b0);
        drive(1'b0, 1'b1, 4'h2, 3'b000, 1'b1, 16'h0410, 3, 1'b0);
        drive(1'b0, 1'b1, 4'h2, 3'b000, 1'b1, 16'h2900, 4, 1'b0);
        fetch(4'h3);
        drive(1'b0, 1'b1, 4'h3, 3'b000, 1'b1, 16'h0088, 2, 1'b0);
        drive(1'b0, 1'b1, 4'h3, 3'b000, 1'b1, 16'h0410, 3, 1'b0);
        drive(1'b0, 1'b1, 4'h3, 3'b000, 1'b1, 16'h3900, 4, 1'b0);

        for (int j = 0; j < 3; j++) begin
            fetch(jops[j]);
            drive(1'b0, 1'b1, jops[j], ~masks[j], 1'b1, 16'h0080, 2, 1'b0);
            fetch(jops[j]);
            drive(1'b0, 1'b1, jops[j], masks[j], 1'b1, 16'h0084, 2, 1'b0);
        end

        fetch(4'h1);
        drive(1'b0, 1'b1, 4'h1, 3'b000, 1'b1, 16'h0088, 2, 1'b0);
        repeat (5) drive(1'b0, 1'b0, 4'h1, 3'b000, 1'b1, 16'h0110, 3, 1'b0);
        drive(1'b1, 1'b1, 4'h1, 3'b000, 1'b1, 16'h0000, 3, 1'b0);
        drive(1'b0, 1'b0, 4'h1, 3'b000, 1'b1, 16'h000A, 0, 1'b0);
        fetch(4'h1);
        drive(1'b0, 1'b1, 4'h1, 3'b000, 1'b1, 16'h0088, 2, 1'b0);
        drive(1'b0, 1'b1, 4'h1, 3'b000, 1'b1, 16'h0110, 3, 1'b0);

        fetch(4'hF);
        drive(1'b0, 1'b1, 4'hF, 3'b000, 1'b1, 16'h8000, 2, 1'b0);
        for (int k = 0; k < 10; k++)
            drive(1'b0, 1'b1, 4'(k), 3'($urandom_range(0, 7)), 1'b1, 16'h8000, 0, 1'b1);
        drive(1'b1, 1'b0, 4'hF, 3'b000, 1'b1, 16'h0000, 0, 1'b1);
        drive(1'b0, 1'b0, 4'hF, 3'b000, 1'b1, 16'h000A, 0, 1'b0);

        for (int op = 0; op < 16; op++) begin
            for (int fl = 0; fl < 8; fl++) begin
                int k;
                k = 0;
                do begin
                    drive(1'b0, 1'b1, 4'(op), 3'(fl), 1'b0, 16'h0000, 0, 1'b0);
                    k++;
                end while (m_pos != 0 && k < 8);
                if (m_halt) drive(1'b1, 1'b0, 4'(op), 3'(fl), 1'b0, 16'h0000, 0, 1'b0);
            end
        end

        for (int c = 0; c < 1500; c++) begin
            bit rst, en;
            rst = m_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 63) == 0);
            en  = ($urandom_range(0, 3) != 0);
            if (m_pos == 0) cur_op = 4'($urandom_range(0, 15));
            drive(rst, en, cur_op, 3'($urandom_range(0, 7)), 1'b0, 16'h0000, 0, 1'b0);
        end

        repeat (2) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
